// File: rtl/axi4_bram_pkg.sv
// Shared types and constants for the AXI4 BRAM arbiter.
//   - AXI response codes
//   - grant encoding for the three requesters (fetch read, data read, data write)
//   - arbiter FSM state encoding
package axi4_bram_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [1:0] {
        G_I  = 2'd0,
        G_DR = 2'd1,
        G_DW = 2'd2
    } grant_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_CAP  = 2'd1,
        RD_RESP = 2'd2,
        WR_RESP = 2'd3
    } state_t;

endpackage

// File: rtl/axi4_bram_arbiter_rr_arb3.sv
// Three-way round-robin arbiter with a registered last-grant pointer.
// Priority order after the last winner is I -> DR -> DW (cyclic).
// Ports:
//   i_clk, i_rst_n : clock, synchronous active-low reset (last <= G_DW)
//   i_req[2:0]     : {DW, DR, I} requests
//   i_update       : commit o_gnt as the new last-grant pointer
//   o_valid        : at least one request pending
//   o_gnt          : combinational winner
module rr_arb3
    import axi4_bram_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [2:0] i_req,
    input  logic       i_update,
    output logic       o_valid,
    output grant_t     o_gnt
);

    grant_t r_last;

    always_comb begin
        o_valid = |i_req;
        o_gnt   = G_I;
        case (r_last)
            G_I: begin
                if (i_req[1])      o_gnt = G_DR;
                else if (i_req[2]) o_gnt = G_DW;
                else               o_gnt = G_I;
            end
            G_DR: begin
                if (i_req[2])      o_gnt = G_DW;
                else if (i_req[0]) o_gnt = G_I;
                else               o_gnt = G_DR;
            end
            default: begin
                if (i_req[0])      o_gnt = G_I;
                else if (i_req[1]) o_gnt = G_DR;
                else               o_gnt = G_DW;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_last <= G_DW;
        end else if (i_update && o_valid) begin
            r_last <= o_gnt;
        end
    end

endmodule

// File: rtl/axi4_bram_arbiter.sv
// Shares one single-port synchronous BRAM between the instruction-fetch AXI4
// read master (i_*) and the data AXI4 read/write master (d_*). One single-beat
// transaction is in flight at a time; out-of-window addresses get DECERR.
// Handshake rule: a transfer happens on a rising edge where valid and ready are
// both high; ready is only ever offered in IDLE, to the arbitration winner, and
// the responder holds R/B payload stable while valid is high and ready is low.
// Ports:
//   CLK, RST_N            : clock, synchronous active-low reset
//   i_ar*/i_r*            : fetch read address / read data channels
//   d_ar*/d_r*            : data read address / read data channels
//   d_aw*/d_w*/d_b*       : data write address / data / response channels
//   mem_*                 : BRAM port (mem_rdata valid one cycle after mem_en)
//   o_dbg_state           : current FSM state
module axi4_bram_arbiter
    import axi4_bram_pkg::*;
#(
    parameter logic [31:0] MEM_BASE  = 32'h0000_0000,
    parameter int          MEM_WORDS = 4096,
    parameter int          AW        = 12,
    parameter int          IDW       = 4
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic           i_arvalid,
    output logic           i_arready,
    input  logic [31:0]    i_araddr,
    input  logic [IDW-1:0] i_arid,
    output logic           i_rvalid,
    input  logic           i_rready,
    output logic [31:0]    i_rdata,
    output logic [1:0]     i_rresp,
    output logic           i_rlast,
    output logic [IDW-1:0] i_rid,
    input  logic           d_arvalid,
    output logic           d_arready,
    input  logic [31:0]    d_araddr,
    input  logic [IDW-1:0] d_arid,
    output logic           d_rvalid,
    input  logic           d_rready,
    output logic [31:0]    d_rdata,
    output logic [1:0]     d_rresp,
    output logic           d_rlast,
    output logic [IDW-1:0] d_rid,
    input  logic           d_awvalid,
    output logic           d_awready,
    input  logic [31:0]    d_awaddr,
    input  logic [IDW-1:0] d_awid,
    input  logic           d_wvalid,
    output logic           d_wready,
    input  logic [31:0]    d_wdata,
    input  logic [3:0]     d_wstrb,
    output logic           d_bvalid,
    input  logic           d_bready,
    output logic [1:0]     d_bresp,
    output logic [IDW-1:0] d_bid,
    output logic           mem_en,
    output logic [3:0]     mem_we,
    output logic [AW-1:0]  mem_addr,
    output logic [31:0]    mem_wdata,
    input  logic [31:0]    mem_rdata,
    output state_t         o_dbg_state
);

    localparam logic [31:0] WIN_BYTES = 32'(MEM_WORDS * 4);

    state_t         r_state;
    grant_t         r_gnt;
    logic [31:0]    r_rdata;
    logic [1:0]     r_rresp;
    logic [IDW-1:0] r_rid;
    logic [1:0]     r_bresp;
    logic [IDW-1:0] r_bid;

    logic [2:0]     w_req;
    logic           w_gnt_valid;
    grant_t         w_gnt;
    logic           w_idle;
    logic           w_fire;
    logic [31:0]    w_addr;
    logic [31:0]    w_off;
    logic [IDW-1:0] w_id;
    logic           w_in;

    // A write only requests when AW and W are both presented together.
    assign w_req = {d_awvalid & d_wvalid, d_arvalid, i_arvalid};

    rr_arb3 u_arb (
        .i_clk    (CLK),
        .i_rst_n  (RST_N),
        .i_req    (w_req),
        .i_update (w_fire),
        .o_valid  (w_gnt_valid),
        .o_gnt    (w_gnt)
    );

    // Readys are masked during reset so no master sees a handshake that the
    // reset is about to discard.
    assign w_idle = (r_state == IDLE) && RST_N;
    assign w_fire = w_idle && w_gnt_valid;

    always_comb begin
        w_addr = i_araddr;
        w_id   = i_arid;
        case (w_gnt)
            G_DR: begin
                w_addr = d_araddr;
                w_id   = d_arid;
            end
            G_DW: begin
                w_addr = d_awaddr;
                w_id   = d_awid;
            end
            default: begin
                w_addr = i_araddr;
                w_id   = i_arid;
            end
        endcase
    end

    // Unsigned subtract-and-compare also rejects addresses below MEM_BASE.
    assign w_off = w_addr - MEM_BASE;
    assign w_in  = (w_off < WIN_BYTES);

    assign i_arready = w_fire && (w_gnt == G_I);
    assign d_arready = w_fire && (w_gnt == G_DR);
    assign d_awready = w_fire && (w_gnt == G_DW);
    assign d_wready  = w_fire && (w_gnt == G_DW);

    assign mem_en    = w_fire && w_in;
    assign mem_we    = (w_fire && w_in && (w_gnt == G_DW)) ? d_wstrb : 4'b0000;
    assign mem_addr  = w_off[AW+1:2];
    assign mem_wdata = d_wdata;

    assign i_rvalid  = (r_state == RD_RESP) && (r_gnt == G_I);
    assign i_rdata   = r_rdata;
    assign i_rresp   = r_rresp;
    assign i_rlast   = 1'b1;
    assign i_rid     = r_rid;

    assign d_rvalid  = (r_state == RD_RESP) && (r_gnt == G_DR);
    assign d_rdata   = r_rdata;
    assign d_rresp   = r_rresp;
    assign d_rlast   = 1'b1;
    assign d_rid     = r_rid;

    assign d_bvalid  = (r_state == WR_RESP);
    assign d_bresp   = r_bresp;
    assign d_bid     = r_bid;

    assign o_dbg_state = r_state;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state <= IDLE;
            r_gnt   <= G_I;
            r_rdata <= '0;
            r_rresp <= OKAY;
            r_rid   <= '0;
            r_bresp <= OKAY;
            r_bid   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_gnt_valid) begin
                        r_gnt <= w_gnt;
                        if (w_gnt == G_DW) begin
                            r_bid   <= w_id;
                            r_bresp <= w_in ? OKAY : DECERR;
                            r_state <= WR_RESP;
                        end else begin
                            // ARID is only guaranteed during the handshake.
                            r_rid <= w_id;
                            if (w_in) begin
                                r_state <= RD_CAP;
                            end else begin
                                r_rdata <= '0;
                                r_rresp <= DECERR;
                                r_state <= RD_RESP;
                            end
                        end
                    end
                end
                RD_CAP: begin
                    r_rdata <= mem_rdata;
                    r_rresp <= OKAY;
                    r_state <= RD_RESP;
                end
                RD_RESP: begin
                    if ((r_gnt == G_I) ? i_rready : d_rready) begin
                        r_state <= IDLE;
                    end
                end
                WR_RESP: begin
                    if (d_bready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
